rs_queue: RTL
=============

# rs_queue

Parametrised, age-ordered reservation station for the out-of-order core; the generic successor to the fixed 4-entry add/multiply/divide station records. It sits between rename/dispatch and one functional unit. It holds renamed instructions until both physical sources are ready, wakes sources from `NUM_CDB` common data buses, and issues the oldest ready entry through a valid/ready handshake. Dispatch, wakeup and issue may all happen in the same cycle.

## Interface
- `DEPTH`, 4: number of entries, ≥2.
- `NUM_CDB`, 1: number of CDB wakeup ports.
- `PREG_W`, 6: physical register index width.
- `ROB_W`, 6: ROB index width.
- `PAYLOAD_W`, 32: opaque payload width (raw instruction word).
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: squash all entries (mispredict recovery).
- `alloc_valid` in 1: dispatch request.
- `alloc_ready` out 1: `occupancy < DEPTH`.
- `alloc_ps1`, `alloc_ps2` in PREG_W each: source physical registers.
- `alloc_ps1_v`, `alloc_ps2_v` in 1 each: source already valid in the physical regfile.
- `alloc_pd` in PREG_W: destination physical register.
- `alloc_rd` in 5: architectural destination.
- `alloc_rob` in ROB_W: ROB index.
- `alloc_payload` in PAYLOAD_W: payload.
- `cdb_valid` in NUM_CDB: per-bus broadcast valid.
- `cdb_pd` in NUM_CDB*PREG_W: per-bus broadcast tag; bus k is bits [k*PREG_W +: PREG_W].
- `issue_valid` out 1: an entry is ready.
- `issue_ready` in 1: functional unit accepts.
- `issue_ps1`, `issue_ps2`, `issue_pd`, `issue_rd`, `issue_rob`, `issue_payload` out: fields of the selected entry.
- `occupancy` out $clog2(DEPTH+1): number of busy entries.

## Operation
- **Storage:** a collapsing queue. Slot 0 is the oldest entry. Busy entries are always contiguous from slot 0.
- **Allocate:** fires when `alloc_valid & alloc_ready`. The new entry goes into slot `occupancy`, or `occupancy-1` if an issue fires in the same cycle.
- **Source readiness at allocate:** a source is ready if any of these holds:
  - its `_v` bit is set;
  - its tag is 0 (p0 is always ready);
  - it matches a valid CDB in the same cycle (allocate-time bypass).
- **Wakeup:** every busy entry compares `ps1` and `ps2` against all valid CDB tags each cycle and sets the ready bit on a match. Ready bits never clear.
- **Select:** the lowest-index busy entry with both sources ready.
  - `issue_valid` is 1 if such an entry exists.
  - All `issue_*` fields are 0 when `issue_valid` is 0.
- **Issue:** fires when `issue_valid & issue_ready`. The selected entry is removed and all younger entries shift down one slot. Wakeups in the same cycle apply to the shifted entries.
- **Flush:** takes priority over everything else. All entries are cleared at the edge, `occupancy` becomes 0, and any same-cycle allocate or issue is discarded. The FU must ignore an issue handshake that coincides with `flush`.
- **No same-cycle slot reuse when full:** `alloc_ready` does not depend on `issue_ready`.
- **Occupancy:** next `occupancy` = `occupancy + alloc_fire - issue_fire`. It never exceeds DEPTH and never wraps below 0.

## Timing
- **Reset values:** `alloc_ready`=1, `issue_valid`=0, all `issue_*`=0, `occupancy`=0; all entries not busy. Reset mid-operation drops every entry immediately (asynchronous).
- **Allocate → issue:** an entry with both sources ready at allocate can issue in the cycle after allocate, at the earliest.
- **CDB → issue:** an entry whose last source is broadcast on a CDB in cycle N issues in cycle N+1 by default (see Configuration).
- **Stall:** with `issue_ready`=0 the selected entry and all `issue_*` outputs stay stable, unless a flush occurs or an older entry becomes ready (the oldest ready entry always wins).
- `alloc_ready` is a registered-state function only; it has no combinational input dependence.

## Configuration
- **`RS_CDB_ISSUE_BYPASS_EN` defined:** select also treats a source as ready if it matches a valid CDB tag in the current cycle.
  - CDB→issue latency is 0 cycles: an entry woken in cycle N issues in cycle N.
  - This adds a combinational path from `cdb_*` to the `issue_*` outputs.
- **Undefined (default):** select uses registered ready bits only; latency is 1 cycle.

## Test plan
- **Reset:** assert `rst` mid-run with 3 entries busy → `occupancy`=0, `issue_valid`=0 and `alloc_ready`=1 immediately, before the next clock edge.
- **Oldest-first:** allocate A (ps1=5, not ready), B (both ready), C (both ready) → B issues first, then C. CDB pd=5 → A issues next. `issue_rob` order is B, C, A.
- **Full, then drain:** fill DEPTH=4 with ready entries and hold `issue_ready`=0 → `alloc_ready`=0 and an alloc attempt is dropped. One issue → `occupancy`=3 and `alloc_ready`=1 in the next cycle.
- **Allocate-time bypass:** allocate an entry with ps1=9, `ps1_v`=0 while `cdb_valid[1]`=1 with `cdb_pd`=9 (NUM_CDB=2) → issues in the next cycle with `issue_ps1`=9.
- **Flush priority:** `flush`, allocate and issue all asserted in the same cycle with 2 busy entries → `occupancy`=0 and `issue_valid`=0 in the next cycle.
- **Macro check:** entry waiting on pd=12, CDB broadcasts 12 in cycle N → `issue_valid` in cycle N with `RS_CDB_ISSUE_BYPASS_EN` defined, in cycle N+1 without it.

Source files
------------

// File: rtl/rs_queue.sv
`default_nettype none
// ============================================================================
// Module      : rs_queue
// Description : Age-ordered collapsing reservation station with CDB wakeup
//               and oldest-ready issue. Optional macro RS_CDB_ISSUE_BYPASS_EN
//               lets select see same-cycle CDB tags (0-cycle wakeup->issue).
// Revision    : 1.0 - initial release
// ============================================================================
module rs_queue #(
    parameter int DEPTH     = 4,
    parameter int NUM_CDB   = 1,
    parameter int PREG_W    = 6,
    parameter int ROB_W     = 6,
    parameter int PAYLOAD_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    input  logic [PREG_W-1:0]            alloc_ps1,
    input  logic [PREG_W-1:0]            alloc_ps2,
    input  logic                         alloc_ps1_v,
    input  logic                         alloc_ps2_v,
    input  logic [PREG_W-1:0]            alloc_pd,
    input  logic [4:0]                   alloc_rd,
    input  logic [ROB_W-1:0]             alloc_rob,
    input  logic [PAYLOAD_W-1:0]         alloc_payload,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB*PREG_W-1:0]    cdb_pd,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [PREG_W-1:0]            issue_ps1,
    output logic [PREG_W-1:0]            issue_ps2,
    output logic [PREG_W-1:0]            issue_pd,
    output logic [4:0]                   issue_rd,
    output logic [ROB_W-1:0]             issue_rob,
    output logic [PAYLOAD_W-1:0]         issue_payload,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int c_OCC_W = $clog2(DEPTH+1);
    localparam int c_IDX_W = $clog2(DEPTH);

    logic [PREG_W-1:0]    r_ps1 [DEPTH];
    logic [PREG_W-1:0]    r_ps2 [DEPTH];
    logic [PREG_W-1:0]    r_pd  [DEPTH];
    logic [4:0]           r_rd  [DEPTH];
    logic [ROB_W-1:0]     r_rob [DEPTH];
    logic [PAYLOAD_W-1:0] r_pay [DEPTH];
    logic [DEPTH-1:0]     r_rdy1, r_rdy2;
    logic [c_OCC_W-1:0]   r_occ;

    logic [PREG_W-1:0]    w_n_ps1 [DEPTH];
    logic [PREG_W-1:0]    w_n_ps2 [DEPTH];
    logic [PREG_W-1:0]    w_n_pd  [DEPTH];
    logic [4:0]           w_n_rd  [DEPTH];
    logic [ROB_W-1:0]     w_n_rob [DEPTH];
    logic [PAYLOAD_W-1:0] w_n_pay [DEPTH];
    logic [DEPTH-1:0]     w_n_rdy1, w_n_rdy2;

    logic [DEPTH-1:0]     w_busy, w_hit1, w_hit2, w_cand;
    logic [c_IDX_W-1:0]   w_sel;
    logic                 w_found;
    logic                 w_alloc_fire, w_issue_fire;
    logic [c_OCC_W-1:0]   w_slot;

    function automatic logic cdb_match(input logic [PREG_W-1:0] tag,
                                       input logic [NUM_CDB-1:0] vld,
                                       input logic [NUM_CDB*PREG_W-1:0] pds);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (vld[k] && (pds[k*PREG_W +: PREG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        w_busy = '0;
        w_hit1 = '0;
        w_hit2 = '0;
        w_cand = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_busy[i] = (c_OCC_W'(i) < r_occ);
            w_hit1[i] = cdb_match(r_ps1[i], cdb_valid, cdb_pd);
            w_hit2[i] = cdb_match(r_ps2[i], cdb_valid, cdb_pd);
`ifdef RS_CDB_ISSUE_BYPASS_EN
            w_cand[i] = w_busy[i] & (r_rdy1[i] | w_hit1[i]) & (r_rdy2[i] | w_hit2[i]);
`else
            w_cand[i] = w_busy[i] & r_rdy1[i] & r_rdy2[i];
`endif
        end
    end

    // Downward scan so the lowest (oldest) candidate is the last one written.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_found = 1'b1;
                w_sel   = c_IDX_W'(i);
            end
        end
    end

    assign alloc_ready   = (r_occ < c_OCC_W'(DEPTH));
    assign w_alloc_fire  = alloc_valid & alloc_ready;
    assign w_issue_fire  = w_found & issue_ready;
    assign w_slot        = r_occ - c_OCC_W'(w_issue_fire);

    assign issue_valid   = w_found;
    assign issue_ps1     = w_found ? r_ps1[w_sel] : '0;
    assign issue_ps2     = w_found ? r_ps2[w_sel] : '0;
    assign issue_pd      = w_found ? r_pd[w_sel]  : '0;
    assign issue_rd      = w_found ? r_rd[w_sel]  : '0;
    assign issue_rob     = w_found ? r_rob[w_sel] : '0;
    assign issue_payload = w_found ? r_pay[w_sel] : '0;
    assign occupancy     = r_occ;

    // Collapse: slots at or above the issued one take their upper neighbour,
    // carrying along any wakeup seen this cycle.
    always_comb begin
        w_n_ps1  = r_ps1;
        w_n_ps2  = r_ps2;
        w_n_pd   = r_pd;
        w_n_rd   = r_rd;
        w_n_rob  = r_rob;
        w_n_pay  = r_pay;
        w_n_rdy1 = r_rdy1;
        w_n_rdy2 = r_rdy2;
        for (int i = 0; i < DEPTH; i++) begin
            int src;
            src = (w_issue_fire && (c_IDX_W'(i) >= w_sel)) ? i + 1 : i;
            if (src < DEPTH) begin
                w_n_ps1[i]  = r_ps1[src];
                w_n_ps2[i]  = r_ps2[src];
                w_n_pd[i]   = r_pd[src];
                w_n_rd[i]   = r_rd[src];
                w_n_rob[i]  = r_rob[src];
                w_n_pay[i]  = r_pay[src];
                w_n_rdy1[i] = r_rdy1[src] | w_hit1[src];
                w_n_rdy2[i] = r_rdy2[src] | w_hit2[src];
            end
        end
        if (w_alloc_fire) begin
            w_n_ps1[w_slot[c_IDX_W-1:0]]  = alloc_ps1;
            w_n_ps2[w_slot[c_IDX_W-1:0]]  = alloc_ps2;
            w_n_pd[w_slot[c_IDX_W-1:0]]   = alloc_pd;
            w_n_rd[w_slot[c_IDX_W-1:0]]   = alloc_rd;
            w_n_rob[w_slot[c_IDX_W-1:0]]  = alloc_rob;
            w_n_pay[w_slot[c_IDX_W-1:0]]  = alloc_payload;
            w_n_rdy1[w_slot[c_IDX_W-1:0]] = alloc_ps1_v | (alloc_ps1 == '0) |
                                            cdb_match(alloc_ps1, cdb_valid, cdb_pd);
            w_n_rdy2[w_slot[c_IDX_W-1:0]] = alloc_ps2_v | (alloc_ps2 == '0) |
                                            cdb_match(alloc_ps2, cdb_valid, cdb_pd);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ  <= '0;
            r_rdy1 <= '0;
            r_rdy2 <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ps1[i] <= '0;
                r_ps2[i] <= '0;
                r_pd[i]  <= '0;
                r_rd[i]  <= '0;
                r_rob[i] <= '0;
                r_pay[i] <= '0;
            end
        end else if (flush) begin
            r_occ  <= '0;
            r_rdy1 <= '0;
            r_rdy2 <= '0;
        end else begin
            r_occ  <= r_occ + c_OCC_W'(w_alloc_fire) - c_OCC_W'(w_issue_fire);
            r_rdy1 <= w_n_rdy1;
            r_rdy2 <= w_n_rdy2;
            r_ps1  <= w_n_ps1;
            r_ps2  <= w_n_ps2;
            r_pd   <= w_n_pd;
            r_rd   <= w_n_rd;
            r_rob  <= w_n_rob;
            r_pay  <= w_n_pay;
        end
    end
endmodule
`default_nettype wire
